// File: rtl/result_collector_pkg.sv
// Shared helpers for the result collector: index-width derivation and
// round-robin index arithmetic used by the arbiter.
package result_collector_pkg;

    // Width of an index over n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Position `offset` steps after `base` on a ring of n entries.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/result_collector_stream_register.sv
// One-entry valid/ready pipeline register used as the register-file output stage.
// Accepts new data when empty or when the current entry is handed off this cycle.
module result_collector_stream_register #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    assign ready_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/result_collector.sv
// Collects execution-unit results through per-EU one-entry buffers, arbitrates them
// round-robin onto the single register-file write port and pulses the retired tag.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int unsigned NumEus      = 2,
    parameter int unsigned NumTags     = 8,
    parameter int unsigned RegWidth    = 32,
    parameter int unsigned WarpWidth   = 4,
    parameter int unsigned NumWarps    = 8,
    parameter int unsigned RegIdxWidth = 8,
    localparam int unsigned TagWidth   = $clog2(NumTags),
    localparam int unsigned WidWidth   = idx_width(NumWarps),
    localparam int unsigned IidWidth   = TagWidth + WidWidth,
    localparam int unsigned DataWidth  = RegWidth * WarpWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumEus-1:0]             eu_to_rc_valid_i,
    output logic [NumEus-1:0]             rc_to_eu_ready_o,
    input  logic [NumEus*IidWidth-1:0]    eu_to_rc_tag_i,
    input  logic [NumEus*RegIdxWidth-1:0] eu_to_rc_dst_i,
    input  logic [NumEus*WarpWidth-1:0]   eu_to_rc_act_mask_i,
    input  logic [NumEus*DataWidth-1:0]   eu_to_rc_data_i,
    output logic                          rc_to_rf_valid_o,
    input  logic                          rf_to_rc_ready_i,
    output logic [WidWidth-1:0]           rc_to_rf_wid_o,
    output logic [RegIdxWidth-1:0]        rc_to_rf_dst_o,
    output logic [WarpWidth-1:0]          rc_to_rf_act_mask_o,
    output logic [DataWidth-1:0]          rc_to_rf_data_o,
    output logic                          rc_to_wl_valid_o,
    output logic [IidWidth-1:0]           rc_to_wl_tag_o
);

    localparam int unsigned PayWidth = IidWidth + RegIdxWidth + WarpWidth + DataWidth;
    localparam int unsigned RrWidth  = idx_width(NumEus);

    logic [NumEus-1:0]   buf_valid_q, buf_valid_d;
    logic [PayWidth-1:0] buf_pay_q [NumEus];
    logic [PayWidth-1:0] buf_pay_d [NumEus];
    logic [RrWidth-1:0]  rr_q, rr_d;

    logic [NumEus-1:0]   buf_taken;
    logic                sel_found;
    logic [RrWidth-1:0]  sel_idx;
    logic [RrWidth-1:0]  cand_idx;
    logic [PayWidth-1:0] sel_pay;
    logic                out_ready;
    logic [PayWidth-1:0] out_pay;
    logic [IidWidth-1:0] out_tag;

    // Round-robin search starting at rr_q; the winner is only consumed when
    // the output register can accept it this cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NumEus; i++) begin
            cand_idx = RrWidth'(rr_index(32'(rr_q), i, NumEus));
            if (!sel_found && buf_valid_q[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
        sel_pay   = buf_pay_q[sel_idx];
        buf_taken = '0;
        rr_d      = rr_q;
        if (sel_found && out_ready) begin
            buf_taken[sel_idx] = 1'b1;
            rr_d               = RrWidth'(rr_index(32'(sel_idx), 1, NumEus));
        end
    end

    // A buffer being drained this cycle can accept a new result in the same cycle.
    always_comb begin
        rc_to_eu_ready_o = '0;
        buf_valid_d      = '0;
        for (int e = 0; e < NumEus; e++) begin
            rc_to_eu_ready_o[e] = !buf_valid_q[e] || buf_taken[e];
            buf_valid_d[e]      = (buf_valid_q[e] && !buf_taken[e])
                                || (eu_to_rc_valid_i[e] && rc_to_eu_ready_o[e]);
            buf_pay_d[e]        = buf_pay_q[e];
            if (eu_to_rc_valid_i[e] && rc_to_eu_ready_o[e]) begin
                buf_pay_d[e] = {eu_to_rc_tag_i[e*IidWidth +: IidWidth],
                                eu_to_rc_dst_i[e*RegIdxWidth +: RegIdxWidth],
                                eu_to_rc_act_mask_i[e*WarpWidth +: WarpWidth],
                                eu_to_rc_data_i[e*DataWidth +: DataWidth]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= '0;
            rr_q        <= '0;
            for (int e = 0; e < NumEus; e++) begin
                buf_pay_q[e] <= '0;
            end
        end else begin
            buf_valid_q <= buf_valid_d;
            rr_q        <= rr_d;
            buf_pay_q   <= buf_pay_d;
        end
    end

    result_collector_stream_register #(
        .Width (PayWidth)
    ) i_out_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (sel_found),
        .ready_o (out_ready),
        .data_i  (sel_pay),
        .valid_o (rc_to_rf_valid_o),
        .ready_i (rf_to_rc_ready_i),
        .data_o  (out_pay)
    );

    assign {out_tag, rc_to_rf_dst_o, rc_to_rf_act_mask_o, rc_to_rf_data_o} = out_pay;
    assign rc_to_rf_wid_o   = out_tag[WidWidth-1:0];
    assign rc_to_wl_valid_o = rc_to_rf_valid_o && rf_to_rc_ready_i;
    assign rc_to_wl_tag_o   = out_tag;

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rc_to_rf_valid_o && !rf_to_rc_ready_i) |=> (rc_to_rf_valid_o && $stable(out_pay)));
    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(buf_taken));
`endif

endmodule

// File: tb/tb_result_collector.sv
// Randomized bench for result_collector: per-EU source queues drive the inputs and a
// scoreboard of accepted results checks every register-file write and retire pulse.
module tb_result_collector;

    localparam int TW = 6;
    localparam int RW = 8;
    localparam int MW = 4;
    localparam int DW = 128;
    localparam int PW = TW + RW + MW + DW;

    logic            clk_i;
    logic            rst_ni;
    logic [1:0]      eu_to_rc_valid_i;
    logic [1:0]      rc_to_eu_ready_o;
    logic [2*TW-1:0] eu_to_rc_tag_i;
    logic [2*RW-1:0] eu_to_rc_dst_i;
    logic [2*MW-1:0] eu_to_rc_act_mask_i;
    logic [2*DW-1:0] eu_to_rc_data_i;
    logic            rc_to_rf_valid_o;
    logic            rf_to_rc_ready_i;
    logic [2:0]      rc_to_rf_wid_o;
    logic [RW-1:0]   rc_to_rf_dst_o;
    logic [MW-1:0]   rc_to_rf_act_mask_o;
    logic [DW-1:0]   rc_to_rf_data_o;
    logic            rc_to_wl_valid_o;
    logic [TW-1:0]   rc_to_wl_tag_o;

    result_collector dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .eu_to_rc_valid_i    (eu_to_rc_valid_i),
        .rc_to_eu_ready_o    (rc_to_eu_ready_o),
        .eu_to_rc_tag_i      (eu_to_rc_tag_i),
        .eu_to_rc_dst_i      (eu_to_rc_dst_i),
        .eu_to_rc_act_mask_i (eu_to_rc_act_mask_i),
        .eu_to_rc_data_i     (eu_to_rc_data_i),
        .rc_to_rf_valid_o    (rc_to_rf_valid_o),
        .rf_to_rc_ready_i    (rf_to_rc_ready_i),
        .rc_to_rf_wid_o      (rc_to_rf_wid_o),
        .rc_to_rf_dst_o      (rc_to_rf_dst_o),
        .rc_to_rf_act_mask_o (rc_to_rf_act_mask_o),
        .rc_to_rf_data_o     (rc_to_rf_data_o),
        .rc_to_wl_valid_o    (rc_to_wl_valid_o),
        .rc_to_wl_tag_o      (rc_to_wl_tag_o)
    );

    // Clock / reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Stimulus sources and scoreboard: exp_q[e] holds results accepted from EU e
    // that have not been written yet, in acceptance order.
    logic [PW-1:0]   src_q [2][$];
    logic [PW-1:0]   exp_q [2][$];
    logic [1:0]      en;
    bit              rf_rdy_cfg;
    bit              rf_rand;
    int              n_checks;
    int              n_pass;
    int              cyc;
    int              wr_eu [$];
    int              wr_cyc [$];
    int              saw_zero_mask;
    bit              prev_stall;
    logic [3+RW+MW+DW-1:0] prev_out;

    function automatic logic [PW-1:0] rand_entry();
        return {TW'($urandom), RW'($urandom), MW'($urandom),
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_model();
        for (int e = 0; e < 2; e++) begin
            src_q[e].delete();
            exp_q[e].delete();
        end
        prev_stall = 1'b0;
    endtask

    // Observe one cycle at the negative edge, before the next active edge commits it.
    task automatic sample();
        logic [PW-1:0]         obs;
        logic [3+RW+MW+DW-1:0] cur_out;
        bit                    hit;
        logic [PW-1:0]         ent;
        cur_out = {rc_to_rf_wid_o, rc_to_rf_dst_o, rc_to_rf_act_mask_o, rc_to_rf_data_o};
        if (prev_stall) begin
            n_checks++;
            if (rc_to_rf_valid_o !== 1'b1 || cur_out !== prev_out)
                $display("FAIL hold_stable: got valid=%b out=%h expected valid=1 out=%h",
                         rc_to_rf_valid_o, cur_out, prev_out);
            else n_pass++;
        end
        n_checks++;
        if (rc_to_wl_valid_o !== (rc_to_rf_valid_o & rf_to_rc_ready_i))
            $display("FAIL retire_pulse: got %b expected %b", rc_to_wl_valid_o,
                     rc_to_rf_valid_o & rf_to_rc_ready_i);
        else n_pass++;
        if (rc_to_rf_valid_o === 1'b1 && rf_to_rc_ready_i === 1'b1) begin
            obs = {rc_to_wl_tag_o, rc_to_rf_dst_o, rc_to_rf_act_mask_o, rc_to_rf_data_o};
            hit = 1'b0;
            ent = '0;
            for (int e = 0; e < 2; e++) begin
                if (!hit && exp_q[e].size() > 0 && exp_q[e][0] === obs) begin
                    hit = 1'b1;
                    ent = exp_q[e].pop_front();
                    wr_eu.push_back(e);
                    wr_cyc.push_back(cyc);
                end
            end
            n_checks++;
            if (!hit)
                $display("FAIL write_match: got %h expected head of EU0/EU1 queue", obs);
            else n_pass++;
            if (hit) begin
                n_checks++;
                if (rc_to_rf_wid_o !== ent[PW-TW +: 3])
                    $display("FAIL write_wid: got %h expected %h", rc_to_rf_wid_o, ent[PW-TW +: 3]);
                else n_pass++;
                if (rc_to_rf_act_mask_o == '0) saw_zero_mask++;
            end
        end
        prev_stall = rc_to_rf_valid_o & !rf_to_rc_ready_i;
        prev_out   = cur_out;
        for (int e = 0; e < 2; e++) begin
            if (eu_to_rc_valid_i[e] && rc_to_eu_ready_o[e])
                exp_q[e].push_back(src_q[e].pop_front());
        end
    endtask

    // Driver: present stimulus just after the active edge, then sample mid-cycle.
    task automatic step();
        logic [PW-1:0] ent;
        @(posedge clk_i);
        #1;
        cyc++;
        for (int e = 0; e < 2; e++) begin
            if (en[e] && src_q[e].size() > 0) begin
                ent = src_q[e][0];
                eu_to_rc_valid_i[e] = 1'b1;
            end else begin
                ent = rand_entry();
                eu_to_rc_valid_i[e] = 1'b0;
            end
            eu_to_rc_tag_i[e*TW +: TW]      = ent[PW-1 -: TW];
            eu_to_rc_dst_i[e*RW +: RW]      = ent[PW-TW-1 -: RW];
            eu_to_rc_act_mask_i[e*MW +: MW] = ent[DW +: MW];
            eu_to_rc_data_i[e*DW +: DW]     = ent[DW-1:0];
        end
        rf_to_rc_ready_i = rf_rand ? 1'($urandom_range(0, 1)) : rf_rdy_cfg;
        @(negedge clk_i);
        sample();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
               && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0)
            $display("FAIL drain_timeout: got %0d results outstanding expected 0",
                     src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size());
        else n_pass++;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        eu_to_rc_valid_i = '0;
        clear_model();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rf_to_rc_ready_i = 1'b1;
        rst_ni = 1'b0;
        #2;
        n_checks++;
        if (rc_to_rf_valid_o !== 1'b0)
            $display("FAIL reset_rf_valid: got %b expected 0", rc_to_rf_valid_o);
        else n_pass++;
        apply_reset();
        n_checks++;
        if (rc_to_eu_ready_o !== 2'b11)
            $display("FAIL reset_eu_ready: got %b expected 11", rc_to_eu_ready_o);
        else n_pass++;
        n_checks++;
        if (rc_to_rf_valid_o !== 1'b0)
            $display("FAIL reset_rf_valid_after: got %b expected 0", rc_to_rf_valid_o);
        else n_pass++;
        n_checks++;
        if (rc_to_wl_valid_o !== 1'b0)
            $display("FAIL reset_wl_valid: got %b expected 0", rc_to_wl_valid_o);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        d = {32'h4, 32'h3, 32'h2, 32'h1};
        en = 2'b01;
        rf_rdy_cfg = 1'b1;
        src_q[0].push_back({6'h0A, 8'd5, 4'b1011, d});
        step();
        n_checks++;
        if (rc_to_eu_ready_o[0] !== 1'b1 || rc_to_rf_valid_o !== 1'b0)
            $display("FAIL single_t0: got ready=%b rf_valid=%b expected ready=1 rf_valid=0",
                     rc_to_eu_ready_o[0], rc_to_rf_valid_o);
        else n_pass++;
        step();
        n_checks++;
        if (rc_to_rf_valid_o !== 1'b0)
            $display("FAIL single_t1: got rf_valid=%b expected 0", rc_to_rf_valid_o);
        else n_pass++;
        step();
        n_checks++;
        if (rc_to_rf_valid_o !== 1'b1 || rc_to_rf_wid_o !== 3'd2 || rc_to_rf_dst_o !== 8'd5
            || rc_to_rf_act_mask_o !== 4'b1011 || rc_to_rf_data_o !== d)
            $display("FAIL single_write: got v=%b wid=%0d dst=%0d mask=%b data=%h expected v=1 wid=2 dst=5 mask=1011 data=%h",
                     rc_to_rf_valid_o, rc_to_rf_wid_o, rc_to_rf_dst_o, rc_to_rf_act_mask_o,
                     rc_to_rf_data_o, d);
        else n_pass++;
        n_checks++;
        if (rc_to_wl_valid_o !== 1'b1 || rc_to_wl_tag_o !== 6'h0A)
            $display("FAIL single_retire: got v=%b tag=%h expected v=1 tag=0a",
                     rc_to_wl_valid_o, rc_to_wl_tag_o);
        else n_pass++;
        drain(10);
    endtask

    task automatic test_back_to_back();
        int base;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            src_q[0].push_back(rand_entry());
            src_q[1].push_back(rand_entry());
        end
        base = wr_eu.size();
        en = 2'b11;
        rf_rdy_cfg = 1'b1;
        drain(60);
        n_checks++;
        if (wr_eu.size() - base != 16)
            $display("FAIL b2b_count: got %0d expected 16", wr_eu.size() - base);
        else n_pass++;
        if (wr_eu.size() - base == 16) begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (wr_eu[base+i] != i % 2)
                    $display("FAIL b2b_order[%0d]: got EU%0d expected EU%0d", i, wr_eu[base+i], i % 2);
                else n_pass++;
            end
            n_checks++;
            if (wr_cyc[base+15] - wr_cyc[base] != 15)
                $display("FAIL b2b_consecutive: got span %0d expected 15", wr_cyc[base+15] - wr_cyc[base]);
            else n_pass++;
        end
    endtask

    task automatic test_drain_refill();
        int base;
        for (int i = 0; i < 12; i++) src_q[1].push_back(rand_entry());
        base = wr_eu.size();
        en = 2'b10;
        rf_rdy_cfg = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (rc_to_eu_ready_o[1] !== 1'b1)
                $display("FAIL refill_ready[%0d]: got %b expected 1", i, rc_to_eu_ready_o[1]);
            else n_pass++;
        end
        drain(20);
        n_checks++;
        if (wr_eu.size() - base != 12)
            $display("FAIL refill_count: got %0d expected 12", wr_eu.size() - base);
        else n_pass++;
        if (wr_eu.size() - base == 12) begin
            n_checks++;
            if (wr_cyc[base+11] - wr_cyc[base] != 11)
                $display("FAIL refill_consecutive: got span %0d expected 11", wr_cyc[base+11] - wr_cyc[base]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 12; i++) begin
            src_q[0].push_back(rand_entry());
            src_q[1].push_back(rand_entry());
        end
        en = 2'b11;
        rf_rdy_cfg = 1'b0;
        repeat (10) step();
        n_checks++;
        if (rc_to_eu_ready_o !== 2'b00 || rc_to_rf_valid_o !== 1'b1)
            $display("FAIL stall_backpressure: got ready=%b rf_valid=%b expected ready=00 rf_valid=1",
                     rc_to_eu_ready_o, rc_to_rf_valid_o);
        else n_pass++;
        rf_rdy_cfg = 1'b1;
        drain(80);
    endtask

    task automatic test_zero_mask();
        logic [PW-1:0] ent;
        ent = rand_entry();
        ent[DW +: MW] = '0;
        saw_zero_mask = 0;
        src_q[0].push_back(ent);
        en = 2'b01;
        rf_rdy_cfg = 1'b1;
        drain(10);
        n_checks++;
        if (saw_zero_mask != 1)
            $display("FAIL zero_mask_write: got %0d writes expected 1", saw_zero_mask);
        else n_pass++;
    endtask

    task automatic test_random();
        rf_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            en = 2'($urandom);
            for (int e = 0; e < 2; e++)
                if (src_q[e].size() < 4 && $urandom_range(0, 2) != 0) src_q[e].push_back(rand_entry());
            step();
        end
        rf_rand = 1'b0;
        rf_rdy_cfg = 1'b1;
        en = 2'b11;
        drain(100);
    endtask

    task automatic test_async_reset();
        int base;
        for (int i = 0; i < 4; i++) begin
            src_q[0].push_back(rand_entry());
            src_q[1].push_back(rand_entry());
        end
        en = 2'b11;
        rf_rdy_cfg = 1'b0;
        repeat (3) step();
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (rc_to_rf_valid_o !== 1'b0 || rc_to_wl_valid_o !== 1'b0 || rc_to_eu_ready_o !== 2'b11)
            $display("FAIL async_reset: got rf_valid=%b wl_valid=%b ready=%b expected 0 0 11",
                     rc_to_rf_valid_o, rc_to_wl_valid_o, rc_to_eu_ready_o);
        else n_pass++;
        clear_model();
        en = 2'b00;
        eu_to_rc_valid_i = '0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        rf_rdy_cfg = 1'b1;
        base = wr_eu.size();
        repeat (6) step();
        n_checks++;
        if (wr_eu.size() != base)
            $display("FAIL post_reset_retire: got %0d writes expected 0", wr_eu.size() - base);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        cyc = 0;
        en = '0;
        rf_rdy_cfg = 1'b1;
        rf_rand = 1'b0;
        saw_zero_mask = 0;
        prev_stall = 1'b0;
        prev_out = '0;
        eu_to_rc_valid_i = '0;
        eu_to_rc_tag_i = '0;
        eu_to_rc_dst_i = '0;
        eu_to_rc_act_mask_i = '0;
        eu_to_rc_data_i = '0;
        rf_to_rc_ready_i = 1'b1;
        rst_ni = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_drain_refill();
        test_stall();
        test_zero_mask();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
